// File: rtl/sample_uart_sender.sv
// sample_uart_sender: streams 16-bit sample RAM words to a byte UART serializer, low byte first.
// Define SAMPLE_UART_SENDER_CHECKSUM_EN to append an XOR checksum byte to every completed run.

module sample_uart_sender #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              START,
  input  logic              STOP,
  input  logic [ADDR_W-1:0] END_ADDR,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_EN,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              TX_START,
  output logic [7:0]        TX_DATA,
  input  logic              TX_BUSY,
  output logic              ACTIVE,
  output logic              DONE,
  output logic [ADDR_W-1:0] WORD_CNT
);

  if (DATA_W != 16) begin : g_data_w_check
    $error("sample_uart_sender: DATA_W must be 16 (two bytes per word)");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_LO_REQ,
    S_LO_WAIT,
    S_HI_REQ,
    S_HI_WAIT,
    S_NEXT
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
    , S_CK_REQ,
    S_CK_WAIT
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] rd_addr_inc;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              busy_seen_q, busy_seen_d;
  logic              start_arm_q, start_arm_d;
  logic              launch, byte_done, in_req, in_wait, abort;
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign rd_addr_inc = rd_addr_q + ADDR_W'(1);
  // START is edge-like: it must be seen high again before it can launch another run.
  assign launch      = (state_q == S_IDLE) && !START && STOP && start_arm_q;
  // A byte is finished only after TX_BUSY has been seen high and then drops.
  assign byte_done   = busy_seen_q && !TX_BUSY;

  always_comb begin
    in_req  = (state_q == S_LO_REQ)  || (state_q == S_HI_REQ);
    in_wait = (state_q == S_LO_WAIT) || (state_q == S_HI_WAIT);
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
    in_req  = in_req  || (state_q == S_CK_REQ);
    in_wait = in_wait || (state_q == S_CK_WAIT);
`endif
  end

  // STOP aborts at once, except that a byte already handed to the serializer is let finish.
  assign abort = (state_q != S_IDLE) && !STOP && (!in_wait || byte_done);

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            if (END_ADDR != '0) state_d = S_READ;
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
            else                state_d = S_CK_REQ;
`endif
          end
        end
        S_READ:    state_d = S_LATCH;
        S_LATCH:   state_d = S_LO_REQ;
        S_LO_REQ:  if (!TX_BUSY) state_d = S_LO_WAIT;
        S_LO_WAIT: if (byte_done) state_d = S_HI_REQ;
        S_HI_REQ:  if (!TX_BUSY) state_d = S_HI_WAIT;
        S_HI_WAIT: if (byte_done) state_d = S_NEXT;
        S_NEXT: begin
          if (rd_addr_inc == end_q) begin
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
            state_d = S_CK_REQ;
`else
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_READ;
          end
        end
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
        S_CK_REQ:  if (!TX_BUSY) state_d = S_CK_WAIT;
        S_CK_WAIT: if (byte_done) state_d = S_IDLE;
`endif
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    end_d       = end_q;
    rd_addr_d   = rd_addr_q;
    word_cnt_d  = word_cnt_q;
    word_d      = word_q;
    tx_data_d   = tx_data_q;
    active_d    = active_q;
    done_d      = 1'b0;
    busy_seen_d = in_req ? 1'b0 : (busy_seen_q | TX_BUSY);
    start_arm_d = START | (start_arm_q & ~launch);
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
    csum_d      = csum_q;
    if (launch)                            csum_d = 8'h00;
    else if (TX_START && state_q != S_CK_REQ) csum_d = csum_q ^ tx_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          end_d      = END_ADDR;
          rd_addr_d  = '0;
          word_cnt_d = '0;
          active_d   = 1'b1;
          if (END_ADDR == '0) begin
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
            tx_data_d = 8'h00;
`else
            done_d    = 1'b1;
            active_d  = 1'b0;
`endif
          end
        end
      end
      S_LATCH: begin
        word_d    = RD_DATA;
        tx_data_d = RD_DATA[7:0];
      end
      S_LO_WAIT: if (byte_done) tx_data_d = word_q[15:8];
      S_NEXT: begin
        rd_addr_d  = rd_addr_inc;
        word_cnt_d = word_cnt_q + ADDR_W'(1);
        if (rd_addr_inc == end_q) begin
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
          tx_data_d = csum_q;
`else
          done_d    = 1'b1;
          active_d  = 1'b0;
`endif
        end
      end
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
      S_CK_WAIT: begin
        if (byte_done) begin
          done_d   = 1'b1;
          active_d = 1'b0;
        end
      end
`endif
      default: ;
    endcase

    if (abort) begin
      active_d   = 1'b0;
      rd_addr_d  = '0;
      word_cnt_d = word_cnt_q;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      end_q       <= '0;
      rd_addr_q   <= '0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      tx_data_q   <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_seen_q <= 1'b0;
      start_arm_q <= 1'b0;
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      end_q       <= end_d;
      rd_addr_q   <= rd_addr_d;
      word_cnt_q  <= word_cnt_d;
      word_q      <= word_d;
      tx_data_q   <= tx_data_d;
      active_q    <= active_d;
      done_q      <= done_d;
      busy_seen_q <= busy_seen_d;
      start_arm_q <= start_arm_d;
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign RD_ADDR  = rd_addr_q;
  assign RD_EN    = (state_q == S_READ);
  assign TX_START = in_req && STOP && !TX_BUSY;
  assign TX_DATA  = tx_data_q;
  assign ACTIVE   = active_q;
  assign DONE     = done_q;
  assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_sample_uart_sender.sv
// Self-checking bench for sample_uart_sender with ADDR_W=3: RAM and serializer models plus a byte-stream reference.
// Expectations follow SAMPLE_UART_SENDER_CHECKSUM_EN when the bench is built with it.

module tb_sample_uart_sender;

  localparam int AW = 3;
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start_n, stop_n;
  logic [AW-1:0] end_addr, rd_addr, word_cnt;
  logic          rd_en, tx_start, tx_busy, active, done;
  logic [15:0]   rd_data;
  logic [7:0]    tx_data;

  always #10 clk = ~clk;

  sample_uart_sender #(.ADDR_W(AW), .DATA_W(16)) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .START   (start_n),
    .STOP    (stop_n),
    .END_ADDR(end_addr),
    .RD_ADDR (rd_addr),
    .RD_EN   (rd_en),
    .RD_DATA (rd_data),
    .TX_START(tx_start),
    .TX_DATA (tx_data),
    .TX_BUSY (tx_busy),
    .ACTIVE  (active),
    .DONE    (done),
    .WORD_CNT(word_cnt)
  );

  // Sample RAM with one cycle read latency.
  logic [15:0] ram [0:7];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // Serializer model: busy for busy_len cycles after each accepted byte.
  int         busy_cnt = 0;
  int         busy_len = 5;
  bit         force_busy = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];
  int         start_while_busy = 0;
  int         unstable = 0;
  int         done_cnt = 0;
  int         errors = 0;
  int         checks = 0;

  assign tx_busy = (busy_cnt != 0) || force_busy;

  always @(posedge clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (tx_data !== cur_byte) unstable++;
    end
    if (tx_start) begin
      if (tx_busy) start_while_busy++;
      tx_q.push_back(tx_data);
      cur_byte <= tx_data;
      busy_cnt <= busy_len;
    end
    if (done) done_cnt++;
  end

  // Reference: words 0..n-1 as low/high byte pairs, optionally followed by their XOR.
  task automatic build_expected(input int n_words, input bit with_ck);
    logic [7:0] ck;
    ck = 8'h00;
    exp_q.delete();
    for (int w = 0; w < n_words; w++) begin
      exp_q.push_back(ram[w][7:0]);
      exp_q.push_back(ram[w][15:8]);
      ck = ck ^ ram[w][7:0] ^ ram[w][15:8];
    end
    if (with_ck) exp_q.push_back(ck);
  endtask

  // Index of first difference between sent and expected bytes; -2 on length mismatch, -1 if equal.
  function automatic int first_diff();
    if (tx_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (tx_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < 8; i++) ram[i] = 16'($urandom);
  endtask

  task automatic settle();
    for (int i = 0; i < 300; i++) begin
      if (!tx_busy) break;
      tick(1);
    end
    tick(2);
    tx_q.delete();
    start_while_busy = 0;
    unstable = 0;
  endtask

  task automatic start_run(input int e);
    end_addr = AW'(e);
    start_n  = 1'b0;
    tick(1);
    start_n  = 1'b1;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_n = 1'b1; stop_n = 1'b1; end_addr = '0;
    tick(2);
    checks++;
    if ({rd_addr, word_cnt, tx_data} !== '0)
      begin errors++; $display("FAIL reset_data: rd_addr=%0d word_cnt=%0d tx_data=%h, required all 0", rd_addr, word_cnt, tx_data); end
    checks++;
    if ({rd_en, tx_start, active, done} !== 4'b0000)
      begin errors++; $display("FAIL reset_ctrl: rd_en,tx_start,active,done=%b, required 0000", {rd_en, tx_start, active, done}); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int base; bit ok; int d;
    settle();
    busy_len = 20;
    ram[0] = 16'h1234; ram[1] = 16'hABCD;
    base = done_cnt;
    start_run(2);
    wait_done(base, ok);
    tick(5);
    build_expected(2, CK);
    d = first_diff();
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: done seen=%0d, required 1", ok); end
    checks++;
    if (d !== -1) begin errors++; $display("FAIL basic_bytes: sent %p, required %p (diff %0d)", tx_q, exp_q, d); end
    checks++;
    if (done_cnt - base !== 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt - base); end
    checks++;
    if (word_cnt !== AW'(2)) begin errors++; $display("FAIL basic_word_cnt: got %0d, required 2", word_cnt); end
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL basic_active: got %b, required 0", active); end
    checks++;
    if (start_while_busy + unstable !== 0)
      begin errors++; $display("FAIL basic_handshake: starts_while_busy=%0d unstable=%0d, required 0/0", start_while_busy, unstable); end
  endtask

  task automatic test_zero_end();
    int base; bit ok; int d;
    settle();
    busy_len = 4;
    base = done_cnt;
    end_addr = '0;
    start_n = 1'b0;
    tick(1);
    start_n = 1'b1;
`ifdef SAMPLE_UART_SENDER_CHECKSUM_EN
    wait_done(base, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout: done seen=%0d, required 1", ok); end
`else
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done_next_cycle: got %b, required 1", done); end
`endif
    tick(5);
    build_expected(0, CK);
    d = first_diff();
    checks++;
    if (d !== -1) begin errors++; $display("FAIL zero_bytes: sent %p, required %p", tx_q, exp_q); end
    checks++;
    if (done_cnt - base !== 1) begin errors++; $display("FAIL zero_done_count: got %0d, required 1", done_cnt - base); end
    checks++;
    if ({word_cnt, active} !== '0) begin errors++; $display("FAIL zero_state: word_cnt=%0d active=%b, required 0/0", word_cnt, active); end
  endtask

  task automatic test_stop();
    int base; bit seen; bit idle; int d;
    settle();
    busy_len = 10;
    randomize_ram();
    base = done_cnt;
    start_run(3);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (tx_q.size() >= 4) begin seen = 1'b1; break; end
      tick(1);
    end
    tick(2);
    stop_n = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!active) begin idle = 1'b1; break; end
      tick(1);
    end
    tick(20);
    stop_n = 1'b1;
    tick(5);
    build_expected(3, 1'b0);
    exp_q = exp_q[0:3];
    d = first_diff();
    checks++;
    if (!(seen && idle)) begin errors++; $display("FAIL stop_timeout: hi byte seen=%0d idle=%0d, required 1/1", seen, idle); end
    checks++;
    if (d !== -1) begin errors++; $display("FAIL stop_bytes: sent %p, required %p", tx_q, exp_q); end
    checks++;
    if (done_cnt !== base) begin errors++; $display("FAIL stop_no_done: got %0d pulses, required 0", done_cnt - base); end
    checks++;
    if (word_cnt !== AW'(1)) begin errors++; $display("FAIL stop_word_cnt: got %0d, required 1", word_cnt); end
    checks++;
    if ({rd_addr, active} !== '0) begin errors++; $display("FAIL stop_state: rd_addr=%0d active=%b, required 0/0", rd_addr, active); end
  endtask

  task automatic test_busy_stuck();
    int base; bit ok; int d;
    settle();
    busy_len = 6;
    randomize_ram();
    force_busy = 1'b1;
    base = done_cnt;
    start_run(1);
    tick(30);
    checks++;
    if (tx_q.size() !== 0) begin errors++; $display("FAIL stuck_no_start: got %0d bytes while busy, required 0", tx_q.size()); end
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL stuck_active: got %b, required 1", active); end
    force_busy = 1'b0;
    wait_done(base, ok);
    tick(3);
    build_expected(1, CK);
    d = first_diff();
    checks++;
    if (!ok || d !== -1) begin errors++; $display("FAIL stuck_bytes: done=%0d sent %p, required %p", ok, tx_q, exp_q); end
    checks++;
    if (start_while_busy !== 0) begin errors++; $display("FAIL stuck_start_while_busy: got %0d, required 0", start_while_busy); end
  endtask

  task automatic test_end_change();
    int base; bit ok; int d;
    settle();
    busy_len = $urandom_range(2, 8);
    randomize_ram();
    base = done_cnt;
    start_run(7);
    tick(40);
    end_addr = AW'(5);
    wait_done(base, ok);
    tick(3);
    build_expected(7, CK);
    d = first_diff();
    checks++;
    if (!ok || d !== -1) begin errors++; $display("FAIL endchg_bytes: done=%0d sent %0d bytes, required %0d (diff %0d)", ok, tx_q.size(), exp_q.size(), d); end
    checks++;
    if (word_cnt !== AW'(7)) begin errors++; $display("FAIL endchg_word_cnt: got %0d, required 7", word_cnt); end
    checks++;
    if (done_cnt - base !== 1) begin errors++; $display("FAIL endchg_done_count: got %0d, required 1", done_cnt - base); end
  endtask

  task automatic test_random();
    int base; bit ok; int d; int e;
    for (int it = 0; it < 4; it++) begin
      settle();
      busy_len = $urandom_range(2, 15);
      randomize_ram();
      e = $urandom_range(1, 7);
      base = done_cnt;
      start_run(e);
      wait_done(base, ok);
      tick(3);
      build_expected(e, CK);
      d = first_diff();
      checks++;
      if (!ok || d !== -1) begin errors++; $display("FAIL rand%0d_bytes: end=%0d done=%0d sent %p, required %p", it, e, ok, tx_q, exp_q); end
      checks++;
      if (word_cnt !== AW'(e)) begin errors++; $display("FAIL rand%0d_word_cnt: got %0d, required %0d", it, word_cnt, e); end
      checks++;
      if (start_while_busy + unstable !== 0)
        begin errors++; $display("FAIL rand%0d_handshake: starts_while_busy=%0d unstable=%0d, required 0/0", it, start_while_busy, unstable); end
    end
  endtask

  task automatic test_back_to_back();
    int base; bit ok;
    settle();
    busy_len = 3;
    randomize_ram();
    base = done_cnt;
    end_addr = AW'(2);
    start_n = 1'b0;
    wait_done(base, ok);
    tick(40);
    build_expected(2, CK);
    checks++;
    if (!ok || done_cnt - base !== 1) begin errors++; $display("FAIL held_start_done: done pulses=%0d, required 1", done_cnt - base); end
    checks++;
    if (active !== 1'b0 || tx_q.size() !== exp_q.size())
      begin errors++; $display("FAIL held_start_retrigger: active=%b bytes=%0d, required 0/%0d", active, tx_q.size(), exp_q.size()); end
    start_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid();
    settle();
    busy_len = 6;
    randomize_ram();
    start_run(5);
    tick(50);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({rd_addr, word_cnt, tx_data} !== '0)
      begin errors++; $display("FAIL midreset_data: rd_addr=%0d word_cnt=%0d tx_data=%h, required all 0", rd_addr, word_cnt, tx_data); end
    checks++;
    if ({rd_en, tx_start, active, done} !== 4'b0000)
      begin errors++; $display("FAIL midreset_ctrl: rd_en,tx_start,active,done=%b, required 0000", {rd_en, tx_start, active, done}); end
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; start_n = 1'b1; stop_n = 1'b1; end_addr = '0;
    for (int i = 0; i < 8; i++) ram[i] = 16'h0000;
    test_reset();
    test_basic();
    test_zero_end();
    test_stop();
    test_busy_stuck();
    test_end_change();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
